// File: rtl/game_counter.sv
// game_counter: up/down counter scoring wrap events into winner/loser tallies, with a one-cycle game-over
module game_counter #(
  parameter int COUNTER_SIZE = 3,
  parameter int BIG_STEP = 2,
  parameter int WIN_LIMIT = 15,
  parameter int LOSE_LIMIT = 15,
  parameter int TALLY_WIDTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    init,
  input  logic [COUNTER_SIZE-1:0] initial_value,
  input  logic                    enable,
  input  logic [1:0]              control,
  output logic [COUNTER_SIZE-1:0] counter,
  output logic                    winner,
  output logic                    loser,
  output logic [TALLY_WIDTH-1:0]  winner_count,
  output logic [TALLY_WIDTH-1:0]  loser_count,
  output logic                    gameover,
  output logic [1:0]              who
);
  typedef enum logic {RUN, OVER} state_t;
  localparam logic [COUNTER_SIZE-1:0] BIG = COUNTER_SIZE'(BIG_STEP);
  localparam logic [COUNTER_SIZE-1:0] ONE = COUNTER_SIZE'(1);
  localparam logic [TALLY_WIDTH-1:0] TMAX = '1;
  localparam logic [TALLY_WIDTH-1:0] WL = TALLY_WIDTH'(WIN_LIMIT);
  localparam logic [TALLY_WIDTH-1:0] LL = TALLY_WIDTH'(LOSE_LIMIT);
  state_t state, state_n;
  logic fresh, hit_zero, hit_ones, lose_end, win_end;
  logic [COUNTER_SIZE-1:0] step, stepped;
  always_comb begin
    step = control[0] ? BIG : ONE;
    stepped = control[1] ? counter - step : counter + step;
    hit_zero = fresh && counter == '0;
    hit_ones = fresh && counter == '1;
    lose_end = loser_count == LL;
    win_end = winner_count == WL;
    state_n = state == OVER ? RUN : (lose_end || win_end) ? OVER : RUN;
  end
  always_ff @(posedge clock) begin
    if (reset) state <= RUN;
    else state <= state_n;
  end
  always_ff @(posedge clock) begin
    if (reset || state == OVER) begin
      counter <= '0;
      fresh <= 1'b0;
      winner <= 1'b0;
      loser <= 1'b0;
      winner_count <= '0;
      loser_count <= '0;
      gameover <= 1'b0;
      who <= 2'b00;
    end else begin
      counter <= init ? initial_value : enable ? stepped : counter;
      fresh <= init | enable;
      winner <= hit_ones;
      loser <= hit_zero;
      winner_count <= winner_count + TALLY_WIDTH'(hit_ones && winner_count != TMAX);
      loser_count <= loser_count + TALLY_WIDTH'(hit_zero && loser_count != TMAX);
      gameover <= state_n == OVER;
      who <= lose_end ? 2'b01 : win_end ? 2'b10 : 2'b00;
    end
  end
endmodule

// File: doc/game_counter.md
GAME_COUNTER -- requirements
Module: game_counter

Interface
REQ-001 The block SHALL have parameter COUNTER_SIZE, default 3, counter width in bits (legal range 2..16).
REQ-002 The block SHALL have parameter BIG_STEP, default 2, step size for control codes 01/11 (legal range 1..2^COUNTER_SIZE-1).
REQ-003 The block SHALL have parameter WIN_LIMIT, default 15, winner tally value that ends the game (legal range 1..2^TALLY_WIDTH-1).
REQ-004 The block SHALL have parameter LOSE_LIMIT, default 15, loser tally value that ends the game (legal range 1..2^TALLY_WIDTH-1).
REQ-005 The block SHALL have parameter TALLY_WIDTH, default 4, width of each tally.
REQ-006 The block SHALL have port clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-008 The block SHALL have port init, input, 1 bit, load request for initial_value.
REQ-009 The block SHALL have port initial_value, input, COUNTER_SIZE bits, value to load.
REQ-010 The block SHALL have port enable, input, 1 bit, count enable: 1 = count, 0 = hold counter.
REQ-011 The block SHALL have port control, input, 2 bits: 00 = +1, 01 = +BIG_STEP, 10 = -1, 11 = -BIG_STEP.
REQ-012 The block SHALL have port counter, output, COUNTER_SIZE bits, registered count.
REQ-013 The block SHALL have port winner, output, 1 bit, one-cycle pulse.
REQ-014 The block SHALL have port loser, output, 1 bit, one-cycle pulse.
REQ-015 The block SHALL have ports winner_count and loser_count, outputs, TALLY_WIDTH bits each, registered tallies.
REQ-016 The block SHALL have port gameover, output, 1 bit, one-cycle pulse.
REQ-017 The block SHALL have port who, output, 2 bits: 00 = none, 01 = loser ended the game, 10 = winner ended the game.

Function
REQ-018 The block SHALL implement a two-state machine: RUN and OVER.
REQ-019 In RUN, counter update priority SHALL be:
- init=1: counter <= initial_value.
- else enable=1: counter <= counter +/- step per control, modulo 2^COUNTER_SIZE (wrap-around, no saturation).
- else: counter holds.
REQ-020 The block SHALL keep an internal fresh flag, set for one cycle after any load or count step, and cleared otherwise.
REQ-021 In RUN, if fresh=1 and counter==0, the next cycle SHALL have loser=1 and loser_count+1.
REQ-022 In RUN, if fresh=1 and counter is all ones, the next cycle SHALL have winner=1 and winner_count+1.
REQ-023 A counter value held with enable=0 SHALL NOT produce repeated winner/loser events.
REQ-024 winner and loser SHALL each be high for exactly one cycle per event and SHALL never be high together.
REQ-025 Tallies SHALL saturate at 2^TALLY_WIDTH-1 and never wrap.
REQ-026 In the cycle in which loser_count==LOSE_LIMIT, the next state SHALL be OVER with who=01.
REQ-027 In the cycle in which winner_count==WIN_LIMIT, the next state SHALL be OVER with who=10.
REQ-028 REQ-026 SHALL take priority over REQ-027 if both conditions hold.
REQ-029 In OVER, which lasts exactly one cycle, gameover SHALL be 1, who SHALL show the ender, counter SHALL hold, init and enable SHALL be ignored, and no events SHALL be detected.
REQ-030 On the cycle after OVER:
- counter, both tallies, who and fresh SHALL be 0.
- state SHALL be RUN.
- this cleared zero SHALL NOT count as a loser event.
REQ-031 init during RUN SHALL take effect the same edge, even while a winner/loser pulse is being output.
REQ-032 The block SHALL operate correctly for any parameter set in legal range with no width truncation of step arithmetic.

Reset
REQ-033 When reset=1 at a rising edge, all state SHALL return to its reset value, overriding init and enable: counter=0, winner=0, loser=0, winner_count=0, loser_count=0, gameover=0, who=00, fresh=0, state=RUN.
REQ-034 A reset mid-OVER or mid-pulse SHALL abort it, so the next cycle shows all outputs at reset values.

Verification
REQ-035 Reset/hold scenario (COUNTER_SIZE=3): reset, then enable=0 for 5 cycles -> counter=0 throughout, no loser pulse.
REQ-036 Load/wrap scenario (COUNTER_SIZE=3): init with initial_value=6, then enable=1, control=00 -> counter 6,7,0,1; winner pulse the cycle after 7, loser pulse the cycle after 0, tallies 1/1.
REQ-037 Big-step scenario (COUNTER_SIZE=3): initial_value=1, control=11 -> counter 1,7,5,... with winner pulse after 7.
REQ-038 Hold scenario (COUNTER_SIZE=3): load 7 then enable=0 for 4 cycles -> exactly one winner pulse, winner_count=1.
REQ-039 Game-end scenario (COUNTER_SIZE=3, LOSE_LIMIT=2): two loser events -> gameover=1 and who=01 for one cycle, then counter and tallies =0 and who=00.
REQ-040 Reset-abort scenario (COUNTER_SIZE=3): assert reset during the OVER cycle -> next cycle gameover=0 and all outputs at reset values.
